branch_target_buffer: RTL and testbench

Parametrised branch-target unit for the pipelined CPU. It stores a small direct-mapped table of taken-branch targets with 2-bit saturating counters, so the IF stage can predict the next PC in the same cycle. It also computes the actual branch target in EX as pc_next + (imme_32 << IMM_SHIFT). When the prediction made in IF is wrong, it issues a registered redirect to the fetch unit.

---
 rtl/branch_target_buffer.sv | 136 +++++++++++++
 tb/tb_branch_target_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, EX-stage target adder
// and a registered redirect to fetch on mispredict.
module branch_target_buffer #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned IMM_SHIFT   = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   if_valid,
    input  logic [INSTR_WIDTH-1:0] if_pc,
    output logic                   pred_hit,
    output logic                   pred_taken,
    output logic [INSTR_WIDTH-1:0] pred_target,
    input  logic                   ex_valid,
    input  logic                   ex_is_branch,
    input  logic                   ex_taken,
    input  logic [INSTR_WIDTH-1:0] ex_pc,
    input  logic [INSTR_WIDTH-1:0] ex_pc_next,
    input  logic [INSTR_WIDTH-1:0] ex_imme_32,
    input  logic                   ex_pred_taken,
    input  logic [INSTR_WIDTH-1:0] ex_pred_target,
    output logic [INSTR_WIDTH-1:0] ex_target,
    output logic                   redirect_valid,
    output logic [INSTR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]   mispredict_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = INSTR_WIDTH - IMM_SHIFT - IDX_W;
    localparam logic [INSTR_WIDTH-1:0] INSTR_SIZE = {{(INSTR_WIDTH-1){1'b0}}, 1'b1} << IMM_SHIFT;

    logic [DEPTH-1:0]                  valid_q;
    logic [DEPTH-1:0][TAG_W-1:0]       tag_q;
    logic [DEPTH-1:0][INSTR_WIDTH-1:0] target_q;
    logic [DEPTH-1:0][1:0]             ctr_q;

    logic                   redirect_valid_q;
    logic [INSTR_WIDTH-1:0] redirect_pc_q;
    logic [CNT_WIDTH-1:0]   mis_cnt_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             lookup_hit, ex_hit, mispredict;
    logic [INSTR_WIDTH-1:0] actual_next;

    // Byte-offset bits of the PCs never address the table.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[IMM_SHIFT-1:0], ex_pc[IMM_SHIFT-1:0]};

    assign if_idx = if_pc[IMM_SHIFT +: IDX_W];
    assign if_tag = if_pc[INSTR_WIDTH-1 -: TAG_W];
    assign ex_idx = ex_pc[IMM_SHIFT +: IDX_W];
    assign ex_tag = ex_pc[INSTR_WIDTH-1 -: TAG_W];

    assign lookup_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_hit    = if_valid && lookup_hit;
    assign pred_taken  = pred_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + INSTR_SIZE;

    assign ex_target   = ex_pc_next + (ex_imme_32 << IMM_SHIFT);
    assign actual_next = ex_taken ? ex_target : ex_pc_next;
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign mispredict  = ex_valid && (ex_is_branch ?
                         ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target))
                         : ex_pred_taken);

    logic                   wr_en, wr_valid;
    logic [TAG_W-1:0]       wr_tag;
    logic [INSTR_WIDTH-1:0] wr_target;
    logic [1:0]             wr_ctr;

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[ex_idx];
        wr_tag    = tag_q[ex_idx];
        wr_target = target_q[ex_idx];
        wr_ctr    = ctr_q[ex_idx];
        if (ex_valid && ex_is_branch) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (ex_taken) begin
                    wr_target = ex_target;
                    if (ctr_q[ex_idx] != 2'b11) wr_ctr = ctr_q[ex_idx] + 2'd1;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    wr_ctr = ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = ex_tag;
                wr_target = ex_target;
                wr_ctr    = 2'b10;
            end
        end else if (ex_valid && ex_pred_taken) begin
            // A non-branch predicted taken means its slot aliases a real branch: drop it.
            wr_en    = 1'b1;
            wr_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {DEPTH{2'b01}};
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[ex_idx]  <= wr_valid;
            tag_q[ex_idx]    <= wr_tag;
            target_q[ex_idx] <= wr_target;
            ctr_q[ex_idx]    <= wr_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mis_cnt_q        <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            redirect_pc_q    <= ex_is_branch ? actual_next : ex_pc_next;
            if (mispredict && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, mid-run reset,
// then randomized traffic against a behavioural model of the table.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = '0, ex_pc_next = '0, ex_imme_32 = '0, ex_pred_target = '0;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;

    branch_target_buffer #(
        .INSTR_WIDTH(32),
        .DEPTH      (16),
        .IMM_SHIFT  (2),
        .CNT_WIDTH  (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_taken        (ex_taken),
        .ex_pc           (ex_pc),
        .ex_pc_next      (ex_pc_next),
        .ex_imme_32      (ex_imme_32),
        .ex_pred_taken   (ex_pred_taken),
        .ex_pred_target  (ex_pred_target),
        .ex_target       (ex_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          flush, ex_valid, is_branch, taken, pred_taken;
        logic [31:0] ex_pc, pc_next, imme, pred_target, exp_target;
        bit          exp_rv;
        logic [31:0] exp_rpc, exp_cnt, lk_pc;
        bit          exp_hit, exp_pt;
        logic [31:0] exp_ptgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input bit fl, input bit ev, input bit br,
                                input bit tk, input bit pt, input logic [31:0] pc,
                                input logic [31:0] pn, input logic [31:0] im,
                                input logic [31:0] ptg, input logic [31:0] etg, input bit rv,
                                input logic [31:0] rpc, input logic [31:0] cnt,
                                input logic [31:0] lk, input bit h, input bit lt,
                                input logic [31:0] ltg);
        vec_t v;
        v.name = name; v.flush = fl; v.ex_valid = ev; v.is_branch = br; v.taken = tk;
        v.pred_taken = pt; v.ex_pc = pc; v.pc_next = pn; v.imme = im; v.pred_target = ptg;
        v.exp_target = etg; v.exp_rv = rv; v.exp_rpc = rpc; v.exp_cnt = cnt; v.lk_pc = lk;
        v.exp_hit = h; v.exp_pt = lt; v.exp_ptgt = ltg;
        return v;
    endfunction

    // Behavioural model of the table and redirect state.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_rv;
    logic [31:0] m_rpc;
    int unsigned m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_rv = 1'b0; m_rpc = '0; m_cnt = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, input bit v, output bit h,
                                          output bit t, output logic [31:0] tg);
        int unsigned i;
        i  = (pc / 4) % 16;
        h  = v && m_valid[i] && (m_tag[i] == pc / 64);
        t  = h && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_step(input bit fl, input bit ev, input bit br, input bit tk,
                                       input bit pt, input logic [31:0] pc,
                                       input logic [31:0] pn, input logic [31:0] im,
                                       input logic [31:0] ptg);
        logic [31:0] t;
        int unsigned i;
        bit mis, h;
        t   = pn + im * 32'd4;
        i   = (pc / 4) % 16;
        mis = ev && (br ? ((pt != tk) || (tk && ptg != t)) : pt);
        m_rv = mis;
        if (mis) begin
            m_rpc = (br && tk) ? t : pn;
            if (m_cnt < 65535) m_cnt++;
        end
        if (fl) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        end else if (ev && br) begin
            h = m_valid[i] && (m_tag[i] == pc / 64);
            if (h) begin
                if (tk) begin
                    m_tgt[i] = t;
                    if (m_ctr[i] < 3) m_ctr[i]++;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end else if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = pc / 64; m_tgt[i] = t; m_ctr[i] = 2;
            end
        end else if (ev && pt) begin
            m_valid[i] = 1'b0;
        end
    endfunction

    initial begin
        vec_t        v;
        bit          h, t;
        logic [31:0] tg, exp_t;

        //      name           fl ev br tk pt  ex_pc         pc_next       imme          pred_tgt      ex_target     rv rpc           cnt lookup_pc     h  t  pred_target
        vecs.push_back(mk("alloc",       0,1,1,1,0, 32'h100, 32'h104, 32'h10, 32'h104, 32'h144, 1,32'h144,1, 32'h100, 1,1,32'h144));
        vecs.push_back(mk("taken2",      0,1,1,1,1, 32'h100, 32'h104, 32'h10, 32'h144, 32'h144, 0,32'h0,  1, 32'h100, 1,1,32'h144));
        vecs.push_back(mk("taken3",      0,1,1,1,1, 32'h100, 32'h104, 32'h10, 32'h144, 32'h144, 0,32'h0,  1, 32'h100, 1,1,32'h144));
        vecs.push_back(mk("not_taken1",  0,1,1,0,1, 32'h100, 32'h104, 32'h10, 32'h144, 32'h144, 1,32'h104,2, 32'h100, 1,1,32'h144));
        vecs.push_back(mk("not_taken2",  0,1,1,0,1, 32'h100, 32'h104, 32'h10, 32'h144, 32'h144, 1,32'h104,3, 32'h100, 1,0,32'h104));
        vecs.push_back(mk("alias_alloc", 0,1,1,1,0, 32'h140, 32'h144, 32'h2F, 32'h144, 32'h200, 1,32'h200,4, 32'h140, 1,1,32'h200));
        vecs.push_back(mk("alias_miss",  0,0,0,0,0, 32'h0,   32'h0,   32'h0,  32'h0,   32'h0,   0,32'h0,  4, 32'h100, 0,0,32'h104));
        vecs.push_back(mk("alias_inval", 0,1,0,0,1, 32'h140, 32'h144, 32'h0,  32'h200, 32'h144, 1,32'h144,5, 32'h140, 0,0,32'h144));
        vecs.push_back(mk("wrap_neg",    0,0,0,0,0, 32'h0, 32'h4, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFC, 0,32'h0,5, 32'h140, 0,0,32'h144));
        vecs.push_back(mk("wrap_pos",    0,0,0,0,0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h1, 32'h0, 32'h0, 0,32'h0,5, 32'h100, 0,0,32'h104));
        vecs.push_back(mk("alloc2",      0,1,1,1,1, 32'h188, 32'h18C, 32'h4,  32'h19C, 32'h19C, 0,32'h0,  5, 32'h188, 1,1,32'h19C));
        vecs.push_back(mk("flush_upd",   1,1,1,1,0, 32'h100, 32'h104, 32'h10, 32'h104, 32'h144, 1,32'h144,6, 32'h100, 0,0,32'h104));
        vecs.push_back(mk("after_flush", 0,0,0,0,0, 32'h0,   32'h0,   32'h0,  32'h0,   32'h0,   0,32'h0,  6, 32'h188, 0,0,32'h18C));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h100;
        #1;
        check("reset_hit", {31'd0, pred_hit}, 32'd0);
        check("reset_taken", {31'd0, pred_taken}, 32'd0);
        check("reset_target", pred_target, 32'h104);
        check("reset_rv", {31'd0, redirect_valid}, 32'd0);
        check("reset_rpc", redirect_pc, 32'd0);
        check("reset_cnt", {16'd0, mispredict_count}, 32'd0);

        foreach (vecs[n]) begin
            v = vecs[n];
            flush = v.flush; ex_valid = v.ex_valid; ex_is_branch = v.is_branch;
            ex_taken = v.taken; ex_pred_taken = v.pred_taken; ex_pc = v.ex_pc;
            ex_pc_next = v.pc_next; ex_imme_32 = v.imme; ex_pred_target = v.pred_target;
            if_valid = 1'b0; if_pc = v.lk_pc;
            #1;
            check({v.name, "_ex_target"}, ex_target, v.exp_target);
            check({v.name, "_idle_hit"}, {31'd0, pred_hit}, 32'd0);
            check({v.name, "_idle_target"}, pred_target, v.lk_pc + 32'd4);
            @(posedge clk);
            #1;
            flush = 1'b0; ex_valid = 1'b0; if_valid = 1'b1;
            #1;
            check({v.name, "_rv"}, {31'd0, redirect_valid}, {31'd0, v.exp_rv});
            if (v.exp_rv) check({v.name, "_rpc"}, redirect_pc, v.exp_rpc);
            check({v.name, "_cnt"}, {16'd0, mispredict_count}, v.exp_cnt);
            check({v.name, "_hit"}, {31'd0, pred_hit}, {31'd0, v.exp_hit});
            check({v.name, "_taken"}, {31'd0, pred_taken}, {31'd0, v.exp_pt});
            check({v.name, "_target"}, pred_target, v.exp_ptgt);
        end

        // Asynchronous reset mid-cycle after a mispredict
        @(negedge clk);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        ex_pc = 32'h100; ex_pc_next = 32'h104; ex_imme_32 = 32'h10; ex_pred_target = 32'h104;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; if_valid = 1'b1; if_pc = 32'h100;
        #1;
        check("pre_reset_rv", {31'd0, redirect_valid}, 32'd1);
        check("pre_reset_hit", {31'd0, pred_hit}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("async_rst_rpc", redirect_pc, 32'd0);
        check("async_rst_cnt", {16'd0, mispredict_count}, 32'd0);
        check("async_rst_hit", {31'd0, pred_hit}, 32'd0);
        check("async_rst_target", pred_target, 32'h104);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            int          s;
            @(negedge clk);
            pc = 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
            s = int'($urandom_range(0, 63)) - 32;
            ex_pc = pc; ex_pc_next = pc + 32'd4; ex_imme_32 = s;
            ex_valid = ($urandom_range(0, 7) != 0);
            ex_is_branch = ($urandom_range(0, 3) != 0);
            ex_taken = $urandom_range(0, 1) == 1;
            flush = ($urandom_range(0, 29) == 0);
            model_predict(pc, 1'b1, h, t, tg);
            ex_pred_taken = t; ex_pred_target = tg;
            if ($urandom_range(0, 3) == 0) begin
                ex_pred_taken = $urandom_range(0, 1) == 1;
                ex_pred_target = ($urandom_range(0, 1) == 1) ? pc + 32'd4 + 32'(s) * 32'd4
                                                             : pc + 32'd4;
            end
            if_valid = ($urandom_range(0, 3) != 0);
            if_pc = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 63)) * 32'd4;
            #1;
            model_predict(if_pc, if_valid, h, t, tg);
            exp_t = ex_pc_next + ex_imme_32 * 32'd4;
            check("rnd_ex_target", ex_target, exp_t);
            check("rnd_hit", {31'd0, pred_hit}, {31'd0, h});
            check("rnd_taken", {31'd0, pred_taken}, {31'd0, t});
            check("rnd_target", pred_target, tg);
            @(posedge clk);
            model_step(flush, ex_valid, ex_is_branch, ex_taken, ex_pred_taken, ex_pc,
                       ex_pc_next, ex_imme_32, ex_pred_target);
            #1;
            check("rnd_rv", {31'd0, redirect_valid}, {31'd0, m_rv});
            if (m_rv) check("rnd_rpc", redirect_pc, m_rpc);
            check("rnd_cnt", {16'd0, mispredict_count}, m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
